decodificador_pwm_servo: RTL and testbench
==========================================

Name: decodificador_pwm_servo

Overview:
Receiver for the 20 ms servo PWM control signal produced by the team's servo controller.
- Measures the high time of each pulse on `pwm_in` and quantizes it back to the 5-bit position code 0..28, i.e. 20°..160° in 5° steps.
- Flags malformed pulses and loss of signal.
- Used for loopback self-test of the turret servo path and for reading an external PWM source.

Parameters:
- CONF_PERIODO, 1000000: nominal PWM period in clock cycles (20 ms at 50 MHz).
- LARGURA_MIN, 35000: pulse width for code 0.
- PASSO, 2675: width increment per code step.
- POSICAO_MAX, 28: highest valid code.
- TIMEOUT, 2000000: cycles without a rising edge before loss of signal is declared.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- pwm_in  in  1  asynchronous PWM input.
- posicao  out  5  last accepted position code.
- posicao_valida  out  1  one-cycle strobe when `posicao` is updated.
- erro  out  1  sticky until next good pulse: last pulse was out of range.
- sem_sinal  out  1  high while no rising edge has been seen for TIMEOUT cycles.
- db_largura  out  20  last measured high width, in cycles.
- db_estado  out  2  FSM state encoding.

Behaviour:
- Reset (reset=0, async): all outputs 0; FSM enters ESPERA_SUBIDA; counters cleared.
- Input conditioning: `pwm_in` passes through a 2-FF synchronizer. Edges are detected on the synchronized value, so detection latency is 2–3 cycles.
- Width counter: 20 bits. It starts at 1 on the rising edge and increments each cycle while high. It saturates at LARGURA_MIN+(POSICAO_MAX+1)*PASSO+1.
- FSM:
  - ESPERA_SUBIDA (00): on a rising edge, go to MEDE_ALTO.
  - MEDE_ALTO (01): on a falling edge, latch width into `db_largura` and go to QUANTIZA. If the counter saturates, set erro=1 and go to ESPERA_SUBIDA only after the falling edge.
  - QUANTIZA (10): first perform the range check.
    - width < LARGURA_MIN−PASSO/2, or width > LARGURA_MIN+POSICAO_MAX*PASSO+PASSO/2: erro=1, posicao unchanged, go to ESPERA_SUBIDA.
    - Otherwise, iterative comparison with no divider. Init k=0, limiar=LARGURA_MIN+PASSO/2 (integer division). Each cycle: if width ≥ limiar and k<POSICAO_MAX, then k++ and limiar+=PASSO; else go to PUBLICA.
    - Latency from falling edge to strobe is at most POSICAO_MAX+5 cycles.
  - PUBLICA (11): posicao←k, posicao_valida=1 for exactly one cycle, erro←0, then go to ESPERA_SUBIDA.
- Edges arriving during QUANTIZA/PUBLICA are ignored. A pulse whose rising edge is missed is discarded.
- Timeout counter: 21 bits, cleared on every rising edge, saturating. `sem_sinal`=1 while count ≥ TIMEOUT. It clears on the next rising edge; the FSM is unaffected.
- Rounding: widths exactly on a threshold round up.
- A glitch pulse shorter than the synchronizer window is not guaranteed to be detected.
- Reset mid-pulse: everything is cleared. The input is still high, so no rising edge is seen and that pulse is skipped. Measurement resumes on the next rising edge.

Optional Feature:
CONFIRMACAO_EN.
- Defined: a decoded code is published only if it equals the code decoded from the immediately preceding good pulse. This requires a 5-bit candidate register plus a candidate-valid flag.
  - An erro pulse or `sem_sinal` clears the candidate-valid flag.
  - The first good pulse after reset never publishes.
- Undefined: every good pulse publishes immediately.

Decomposition:
- Shared package pwm_servo_pkg holds:
  - the FSM state enum (ESPERA_SUBIDA, MEDE_ALTO, QUANTIZA, PUBLICA);
  - localparams CONF_PERIODO, LARGURA_MIN, PASSO, POSICAO_MAX;
  - these constants are shared with the controller so both ends stay consistent.
- One natural sub-module: sincronizador_borda. It contains the 2-FF synchronizer plus rising/falling edge strobes.

Test Plan:
- 35000-cycle pulse every 1000000 cycles → posicao=0, one posicao_valida strobe per period, erro=0.
- Pulses of 77800 and then 109900 cycles → posicao=16, then posicao=28.
- 36336 / 36337 cycle pulses → posicao=0 / posicao=1 (threshold boundary).
- 20000-cycle pulse after a good code 5 → erro=1, posicao stays 5, no strobe. A following 48375 pulse → posicao=5, erro=0.
- `pwm_in` held low 2000000 cycles after a pulse → sem_sinal=1. It returns to 0 within 3 cycles of the next rising edge.
- reset=0 asserted at cycle 20000 inside a 60000-cycle pulse → outputs 0 immediately, that pulse is not decoded, and the next 56400 pulse → posicao=8.
- With CONFIRMACAO_EN, pulses 8 then 9 then 9 → only the third pulse strobes, with posicao=9.

Source files
------------

// File: rtl/pwm_servo_pkg.sv
// Constants and FSM state type shared by the servo PWM controller and the decoder,
// so both ends of the link agree on period, base width and step size.
package pwm_servo_pkg;

    typedef enum logic [1:0] {
        ESPERA_SUBIDA = 2'b00,
        MEDE_ALTO     = 2'b01,
        QUANTIZA      = 2'b10,
        PUBLICA       = 2'b11
    } estado_t;

    localparam int CONF_PERIODO = 1000000;
    localparam int LARGURA_MIN  = 35000;
    localparam int PASSO        = 2675;
    localparam int POSICAO_MAX  = 28;

endpackage

// File: rtl/decodificador_pwm_servo_sincronizador_borda.sv
// Two-flop synchronizer for the asynchronous PWM input with rising/falling edge strobes.
module sincronizador_borda (
    input  logic clock,
    input  logic reset,
    input  logic i_assinc,
    output logic o_subida,
    output logic o_descida
);

    logic r_meta;
    logic r_sync;
    logic r_anterior;

    // Chain resets to 1 so a pulse already high when reset is released never looks like a rising edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta     <= 1'b1;
            r_sync     <= 1'b1;
            r_anterior <= 1'b1;
        end else begin
            r_meta     <= i_assinc;
            r_sync     <= r_meta;
            r_anterior <= r_sync;
        end
    end

    assign o_subida  = r_sync & ~r_anterior;
    assign o_descida = ~r_sync & r_anterior;

endmodule

// File: rtl/decodificador_pwm_servo.sv
// Servo PWM receiver: measures each pulse's high time and decodes it to a 0..28 position code.
// Optional macro CONFIRMACAO_EN: publish a code only when two consecutive good pulses agree.
module decodificador_pwm_servo
    import pwm_servo_pkg::*;
#(
    parameter int CONF_PERIODO = pwm_servo_pkg::CONF_PERIODO,
    parameter int LARGURA_MIN  = pwm_servo_pkg::LARGURA_MIN,
    parameter int PASSO        = pwm_servo_pkg::PASSO,
    parameter int POSICAO_MAX  = pwm_servo_pkg::POSICAO_MAX,
    parameter int TIMEOUT      = 2 * CONF_PERIODO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [4:0]  posicao,
    output logic        posicao_valida,
    output logic        erro,
    output logic        sem_sinal,
    output logic [19:0] db_largura,
    output logic [1:0]  db_estado
);

    localparam logic [19:0] LARGURA_SAT    = 20'(LARGURA_MIN + (POSICAO_MAX + 1) * PASSO + 1);
    localparam logic [19:0] LIMITE_INF     = 20'(LARGURA_MIN - PASSO / 2);
    localparam logic [19:0] LIMITE_SUP     = 20'(LARGURA_MIN + POSICAO_MAX * PASSO + PASSO / 2);
    localparam logic [19:0] LIMIAR_INICIAL = 20'(LARGURA_MIN + PASSO / 2);
    localparam logic [19:0] PASSO_L        = 20'(PASSO);
    localparam logic [4:0]  K_MAX          = 5'(POSICAO_MAX);
    localparam logic [20:0] LIMITE_TIMEOUT = 21'(TIMEOUT);

    logic        w_subida;
    logic        w_descida;
    estado_t     r_estado;
    logic [19:0] r_largura;
    logic [19:0] r_db_largura;
    logic [19:0] r_limiar;
    logic [4:0]  r_k;
    logic [4:0]  r_posicao;
    logic        r_checado;
    logic        r_valida;
    logic        r_erro;
    logic [20:0] r_timeout;
    logic        r_sem_sinal;
`ifdef CONFIRMACAO_EN
    logic [4:0]  r_candidato;
    logic        r_candidato_valido;
`endif

    sincronizador_borda u_sincronizador (
        .clock     (clock),
        .reset     (reset),
        .i_assinc  (pwm_in),
        .o_subida  (w_subida),
        .o_descida (w_descida)
    );

    // Loss-of-signal watchdog runs independently of the FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timeout   <= '0;
            r_sem_sinal <= 1'b0;
        end else if (w_subida) begin
            r_timeout   <= '0;
            r_sem_sinal <= 1'b0;
        end else begin
            if (r_timeout < LIMITE_TIMEOUT)
                r_timeout <= r_timeout + 21'd1;
            r_sem_sinal <= (r_timeout >= LIMITE_TIMEOUT);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado     <= ESPERA_SUBIDA;
            r_largura    <= '0;
            r_db_largura <= '0;
            r_limiar     <= '0;
            r_k          <= '0;
            r_posicao    <= '0;
            r_checado    <= 1'b0;
            r_valida     <= 1'b0;
            r_erro       <= 1'b0;
`ifdef CONFIRMACAO_EN
            r_candidato        <= '0;
            r_candidato_valido <= 1'b0;
`endif
        end else begin
            r_valida <= 1'b0;
`ifdef CONFIRMACAO_EN
            if (r_sem_sinal)
                r_candidato_valido <= 1'b0;
`endif
            case (r_estado)
                ESPERA_SUBIDA: begin
                    if (w_subida) begin
                        r_largura <= 20'd1;
                        r_estado  <= MEDE_ALTO;
                    end
                end
                MEDE_ALTO: begin
                    if (w_descida) begin
                        r_db_largura <= r_largura;
                        r_checado    <= 1'b0;
                        r_k          <= '0;
                        r_limiar     <= LIMIAR_INICIAL;
                        if (r_largura >= LARGURA_SAT) begin
                            r_erro   <= 1'b1;
`ifdef CONFIRMACAO_EN
                            r_candidato_valido <= 1'b0;
`endif
                            r_estado <= ESPERA_SUBIDA;
                        end else begin
                            r_estado <= QUANTIZA;
                        end
                    end else if (r_largura < LARGURA_SAT) begin
                        r_largura <= r_largura + 20'd1;
                    end
                end
                QUANTIZA: begin
                    // First cycle is the range check; the rest walk thresholds instead of dividing.
                    if (!r_checado) begin
                        if (r_db_largura < LIMITE_INF || r_db_largura > LIMITE_SUP) begin
                            r_erro   <= 1'b1;
`ifdef CONFIRMACAO_EN
                            r_candidato_valido <= 1'b0;
`endif
                            r_estado <= ESPERA_SUBIDA;
                        end else begin
                            r_checado <= 1'b1;
                        end
                    end else if (r_db_largura >= r_limiar && r_k < K_MAX) begin
                        r_k      <= r_k + 5'd1;
                        r_limiar <= r_limiar + PASSO_L;
                    end else begin
                        r_estado <= PUBLICA;
                    end
                end
                PUBLICA: begin
                    r_erro <= 1'b0;
`ifdef CONFIRMACAO_EN
                    if (r_candidato_valido && r_candidato == r_k) begin
                        r_posicao <= r_k;
                        r_valida  <= 1'b1;
                    end
                    r_candidato        <= r_k;
                    r_candidato_valido <= 1'b1;
`else
                    r_posicao <= r_k;
                    r_valida  <= 1'b1;
`endif
                    r_estado <= ESPERA_SUBIDA;
                end
                default: r_estado <= ESPERA_SUBIDA;
            endcase
        end
    end

    assign posicao        = r_posicao;
    assign posicao_valida = r_valida;
    assign erro           = r_erro;
    assign sem_sinal      = r_sem_sinal;
    assign db_largura     = r_db_largura;
    assign db_estado      = r_estado;

endmodule

// File: tb/tb_decodificador_pwm_servo.sv
// Directed bench for decodificador_pwm_servo with scaled-down timing and a strobe scoreboard.
module tb_decodificador_pwm_servo;

    localparam int T_PERIODO = 1000;
    localparam int T_LMIN    = 70;
    localparam int T_PASSO   = 10;
    localparam int T_MAX     = 28;
    localparam int T_TIMEOUT = 2000;
    localparam int T_SAT     = T_LMIN + (T_MAX + 1) * T_PASSO + 1;
    localparam int T_INTERVALO = 100;

    logic        clock;
    logic        reset;
    logic        pwm_in;
    logic [4:0]  posicao;
    logic        posicao_valida;
    logic        erro;
    logic        sem_sinal;
    logic [19:0] db_largura;
    logic [1:0]  db_estado;

    int nAsserts = 0;
    int nFails   = 0;
    int nStrobes = 0;
    int expStrobes = 0;
    int expPos   = 0;
    int expErro  = 0;
    int cand     = 0;
    int candValido = 0;
    int expQ[$];

    decodificador_pwm_servo #(
        .CONF_PERIODO (T_PERIODO),
        .LARGURA_MIN  (T_LMIN),
        .PASSO        (T_PASSO),
        .POSICAO_MAX  (T_MAX),
        .TIMEOUT      (T_TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pwm_in         (pwm_in),
        .posicao        (posicao),
        .posicao_valida (posicao_valida),
        .erro           (erro),
        .sem_sinal      (sem_sinal),
        .db_largura     (db_largura),
        .db_estado      (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference decode by arithmetic; -1 means the pulse must be rejected.
    function automatic int codigoEsperado(input int largura);
        int w;
        int k;
        w = (largura > T_SAT) ? T_SAT : largura;
        if (w < T_LMIN - T_PASSO / 2 || w > T_LMIN + T_MAX * T_PASSO + T_PASSO / 2)
            return -1;
        if (w < T_LMIN + T_PASSO / 2)
            return 0;
        k = (w - T_LMIN - T_PASSO / 2) / T_PASSO + 1;
        return (k > T_MAX) ? T_MAX : k;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (posicao_valida === 1'b1) begin
            nStrobes++;
            nAsserts++;
            assert (expQ.size() > 0)
            else begin
                nFails++;
                $error("[TB] FAIL strobe_inesperado: observed strobe with posicao %0d expected none", posicao);
            end
            if (expQ.size() > 0)
                checkOutput("posicao_strobe", 32'(posicao), 32'(expQ.pop_front()));
        end
    end

    task automatic publica(input int codigo);
        expQ.push_back(codigo);
        expPos = codigo;
        expStrobes++;
    endtask

    task automatic applyStimulus(input int largura);
        int codigo;
        codigo = codigoEsperado(largura);
        if (codigo < 0) begin
            expErro = 1;
            candValido = 0;
        end else begin
            expErro = 0;
`ifdef CONFIRMACAO_EN
            if (candValido != 0 && cand == codigo)
                publica(codigo);
            cand = codigo;
            candValido = 1;
`else
            publica(codigo);
`endif
        end
        pwm_in = 1'b1;
        for (int i = 1; i <= largura; i++) begin
            @(negedge clock);
            if (i == 3)
                checkOutput("sem_sinal_na_subida", 32'(sem_sinal), 32'd0);
        end
        pwm_in = 1'b0;
        repeat (T_INTERVALO) @(negedge clock);
        checkOutput($sformatf("erro_w%0d", largura), 32'(erro), 32'(expErro));
        checkOutput($sformatf("posicao_w%0d", largura), 32'(posicao), 32'(expPos));
        checkOutput($sformatf("strobes_w%0d", largura), 32'(nStrobes), 32'(expStrobes));
        checkOutput($sformatf("largura_w%0d", largura), 32'(db_largura),
                    32'((largura > T_SAT) ? T_SAT : largura));
        checkOutput($sformatf("estado_w%0d", largura), 32'(db_estado), 32'd0);
    endtask

    initial begin
        reset  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_posicao", 32'(posicao), 32'd0);
        checkOutput("reset_valida", 32'(posicao_valida), 32'd0);
        checkOutput("reset_erro", 32'(erro), 32'd0);
        checkOutput("reset_sem_sinal", 32'(sem_sinal), 32'd0);
        checkOutput("reset_largura", 32'(db_largura), 32'd0);
        checkOutput("reset_estado", 32'(db_estado), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        applyStimulus(70);
        applyStimulus(70);
        applyStimulus(70);
        applyStimulus(230);
        applyStimulus(350);
        applyStimulus(74);
        applyStimulus(75);
        applyStimulus(120);
        applyStimulus(40);
        applyStimulus(120);
        applyStimulus(355);
        applyStimulus(356);
        applyStimulus(400);
        applyStimulus(120);

        checkOutput("sem_sinal_antes", 32'(sem_sinal), 32'd0);
        repeat (T_TIMEOUT) @(negedge clock);
        checkOutput("sem_sinal_timeout", 32'(sem_sinal), 32'd1);
        checkOutput("estado_timeout", 32'(db_estado), 32'd0);
        candValido = 0;
        applyStimulus(70);

        pwm_in = 1'b1;
        repeat (40) @(negedge clock);
        checkOutput("estado_meio_pulso", 32'(db_estado), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("reset_meio_posicao", 32'(posicao), 32'd0);
        checkOutput("reset_meio_largura", 32'(db_largura), 32'd0);
        checkOutput("reset_meio_estado", 32'(db_estado), 32'd0);
        expPos = 0;
        expErro = 0;
        candValido = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (80) @(negedge clock);
        pwm_in = 1'b0;
        repeat (T_INTERVALO) @(negedge clock);
        checkOutput("pulso_cortado_posicao", 32'(posicao), 32'd0);
        checkOutput("pulso_cortado_strobes", 32'(nStrobes), 32'(expStrobes));
        checkOutput("pulso_cortado_estado", 32'(db_estado), 32'd0);

        applyStimulus(150);
        applyStimulus(160);
        applyStimulus(160);

        checkOutput("fila_pendente", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
